// File: rtl/lut_parity_engine.sv
// Programmable K-input lookup table with double-buffered serial load,
// registered evaluation and a per-frame XOR accumulator.
module lut_parity_engine #(
    parameter int K     = 3,
    parameter int TBL_W = 2**K,
    parameter int CNT_W = K+1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_bit,
    output logic         cfg_busy,
    output logic         cfg_done,
    input  logic         in_valid,
    input  logic [K-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    output logic         out_y,
    output logic         acc_valid,
    output logic         acc_y
);

    typedef enum logic {IDLE, LOAD} state_t;

    // Odd-parity table: bit i is the XOR-reduction of its own index.
    function automatic logic [TBL_W-1:0] parity_table();
        logic [TBL_W-1:0] t;
        t = '0;
        for (int i = 0; i < TBL_W; i++) begin
            t[i] = ^(i[K-1:0]);
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] PARITY   = parity_table();
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TBL_W);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [TBL_W-1:0] shadow;
    logic [TBL_W-1:0] active;
    logic             acc;
    logic             lut_bit;

    // Evaluation always reads the committed table, never the shadow.
    assign lut_bit = active[in_data];

    // Serial load into the shadow table; commit one cycle after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            shadow   <= '0;
            active   <= PARITY;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        shadow[0] <= cfg_bit;
                        count     <= CNT_W'(1);
                        state     <= LOAD;
                        cfg_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (count == CNT_FULL) begin
                        active   <= shadow;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end else if (cfg_en) begin
                        shadow[count[K-1:0]] <= cfg_bit;
                        count                <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered lookup result; out_y keeps its value between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_y <= lut_bit;
            end
        end
    end

    // Fold every result of a frame and publish the summary on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 1'b0;
            acc_valid <= 1'b0;
            acc_y     <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (in_valid) begin
                if (in_last) begin
                    acc_y     <= acc ^ lut_bit;
                    acc_valid <= 1'b1;
                    acc       <= 1'b0;
                end else begin
                    acc <= acc ^ lut_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_parity_engine.sv
// Directed bench for lut_parity_engine with a queue-based reference model
// and literal checks taken from hand-worked scenarios.
module tb_lut_parity_engine;

    localparam int K     = 3;
    localparam int TBL_W = 2**K;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_en = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_busy;
    logic         cfg_done;
    logic         in_valid = 1'b0;
    logic [K-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_y;
    logic         acc_valid;
    logic         acc_y;

    lut_parity_engine #(.K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_y     (out_y),
        .acc_valid (acc_valid),
        .acc_y     (acc_y)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [TBL_W-1:0] m_tbl;
    bit               m_bits[$];
    bit               m_frame[$];
    logic             m_busy, m_done, m_ov, m_oy, m_av, m_ay;

    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TBL_W; i++) m_tbl[i] = ($countones(i) % 2) == 1;
        m_bits.delete();
        m_frame.delete();
        m_busy = 0; m_done = 0; m_ov = 0; m_oy = 0; m_av = 0; m_ay = 0;
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        logic y;
        logic x;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_done = 0;
            m_av   = 0;
            m_ov   = in_valid;
            if (in_valid) begin
                y    = m_tbl[in_data];
                m_oy = y;
                if (in_last) begin
                    x = y;
                    foreach (m_frame[i]) x ^= m_frame[i];
                    m_ay = x;
                    m_av = 1;
                    m_frame.delete();
                end else begin
                    m_frame.push_back(y);
                end
            end
            if (m_bits.size() == TBL_W) begin
                for (int i = 0; i < TBL_W; i++) m_tbl[i] = m_bits[i];
                m_bits.delete();
                m_done = 1;
            end else if (cfg_en) begin
                m_bits.push_back(cfg_bit);
            end
            m_busy = m_bits.size() != 0;
        end
        #1;
        chk("cfg_busy",  cfg_busy,  m_busy);
        chk("cfg_done",  cfg_done,  m_done);
        chk("out_valid", out_valid, m_ov);
        chk("out_y",     out_y,     m_oy);
        chk("acc_valid", acc_valid, m_av);
        chk("acc_y",     acc_y,     m_ay);
    endtask

    task automatic drive(input logic en, input logic b, input logic v,
                         input logic [K-1:0] d, input logic l, input logic r);
        cfg_en = en; cfg_bit = b; in_valid = v;
        in_data = d; in_last = l; rst = r;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0);
    endtask

    task automatic eval(input logic [K-1:0] d, input logic l);
        drive(0, 0, 1, d, l, 0);
    endtask

    task automatic load_bit(input logic b);
        drive(1, b, 0, '0, 0, 0);
    endtask

    logic [7:0] lit_par;
    logic [7:0] pat;
    int         busy_cnt;
    int         done_cnt;

    initial begin
        model_reset();
        lit_par = 8'h96;

        drive(0, 0, 0, '0, 0, 1);
        drive(0, 0, 0, '0, 0, 1);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_oy", out_y, 1'b0);
        idle();

        // Parity sweep, back-to-back
        for (int i = 0; i < TBL_W; i++) begin
            eval(K'(i), 0);
            chk("sweep_oy", out_y, lit_par[i]);
            chk("sweep_ov", out_valid, 1'b1);
        end
        idle();

        // Load 0x80
        pat = 8'h80;
        busy_cnt = 0;
        done_cnt = 0;
        for (int b = 0; b < TBL_W; b++) begin
            load_bit(pat[b]);
            if (cfg_busy) busy_cnt++;
            if (cfg_done) done_cnt++;
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            if (cfg_busy) busy_cnt++;
            if (cfg_done) done_cnt++;
        end
        chk("load80_busy8", busy_cnt == 8, 1'b1);
        chk("load80_done1", done_cnt == 1, 1'b1);
        eval(3'd7, 0);
        chk("t80_d7", out_y, 1'b1);
        eval(3'd6, 0);
        chk("t80_d6", out_y, 1'b0);
        idle();

        // Load 0xFF with a 3-cycle pause after bit 4
        for (int b = 0; b < 5; b++) load_bit(1'b1);
        for (int c = 0; c < 3; c++) begin
            idle();
            chk("pause_busy", cfg_busy, 1'b1);
            chk("pause_done", cfg_done, 1'b0);
        end
        for (int b = 5; b < TBL_W; b++) load_bit(1'b1);
        chk("ff_busy_last", cfg_busy, 1'b1);
        idle();
        chk("ff_done", cfg_done, 1'b1);
        eval(3'd3, 0);
        chk("tff_d3", out_y, 1'b1);
        eval(3'd0, 0);
        chk("tff_d0", out_y, 1'b1);

        // Commit collision: 0x00 over parity
        drive(0, 0, 0, '0, 0, 1);
        for (int b = 0; b < TBL_W; b++) load_bit(1'b0);
        eval(3'd7, 0);
        chk("coll_done", cfg_done, 1'b1);
        chk("coll_old", out_y, 1'b1);
        eval(3'd7, 0);
        chk("coll_new", out_y, 1'b0);

        // Frames over parity
        drive(0, 0, 0, '0, 0, 1);
        eval(3'd1, 0);
        eval(3'd2, 0);
        chk("fr1_noav", acc_valid, 1'b0);
        eval(3'd3, 1);
        chk("fr1_av", acc_valid, 1'b1);
        chk("fr1_ay", acc_y, 1'b0);
        eval(3'd4, 1);
        chk("fr2_av", acc_valid, 1'b1);
        chk("fr2_ay", acc_y, 1'b1);
        idle();
        chk("fr2_pulse", acc_valid, 1'b0);
        chk("fr2_hold", acc_y, 1'b1);

        // Reset mid-load and mid-frame
        drive(1, 0, 1, 3'd1, 0, 0);
        for (int b = 1; b < 5; b++) load_bit(1'b0);
        drive(0, 0, 0, '0, 0, 1);
        chk("mid_busy", cfg_busy, 1'b0);
        chk("mid_ay", acc_y, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (cfg_done) done_cnt++;
        end
        chk("mid_nodone", done_cnt == 0, 1'b1);
        eval(3'd1, 1);
        chk("mid_par_d1", out_y, 1'b1);
        chk("mid_single", acc_y, 1'b1);
        eval(3'd7, 1);
        chk("mid_fr7_av", acc_valid, 1'b1);
        chk("mid_fr7_ay", acc_y, 1'b1);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lut_parity_engine.md
Name: lut_parity_engine

Overview:
- Programmable K-input truth-table function unit. Generalises the fixed 3-input XOR lookup.
- The 2^K-bit table is loaded serially at run time and double-buffered, so evaluation never stalls during a reload.
- Evaluation output is registered (1-cycle latency).
- A per-frame accumulator XOR-folds every LUT result in a frame and reports one summary bit at frame end.
- Sits between input sampling and downstream check logic as a generic parity/function slice.

Parameters:
- K, 3, number of LUT inputs; legal range 1..6.
- TBL_W, 2**K, table width in bits; derived, do not override.
- CNT_W, K+1, load counter width; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_en  in  1  qualifies cfg_bit this cycle.
- cfg_bit  in  1  serial table bit, LSB (index 0) first.
- cfg_busy  out  1  high while a load is in progress.
- cfg_done  out  1  one-cycle pulse when the new table commits.
- in_valid  in  1  evaluation request.
- in_data  in  K  LUT address; in_data[K-1] is MSB.
- in_last  in  1  marks the final beat of a frame; qualified by in_valid.
- out_valid  out  1  registered copy of in_valid.
- out_y  out  1  table[in_data] from the request cycle.
- acc_valid  out  1  one-cycle pulse, frame summary valid.
- acc_y  out  1  XOR of all out_y values in the frame, including the last beat.

Behaviour:
- Reset values:
  - Active table = odd parity: bit i = XOR-reduce of i. For K=3 this is 0x96.
  - shadow = 0, count = 0, state = IDLE.
  - cfg_busy, cfg_done, out_valid, out_y, acc_valid, acc_y and acc all 0.
- Load FSM, states IDLE and LOAD:
  - IDLE with cfg_en=1: shadow[0] <= cfg_bit, count <= 1, go to LOAD, cfg_busy <= 1.
  - LOAD with cfg_en=1: shadow[count] <= cfg_bit, count++.
  - When the bit written is index TBL_W-1, the next cycle has: active <= shadow (including that bit), cfg_done=1, cfg_busy=0, count=0, state IDLE.
  - LOAD with cfg_en=0: hold; no timeout. A load may pause indefinitely.
  - cfg_done stays asserted for exactly one cycle.
  - Shadow contents are never visible to evaluation before commit.
- Evaluation:
  - out_valid <= in_valid; out_y <= active[in_data] when in_valid, otherwise out_y holds its value.
  - Latency is 1 cycle, with full throughput (one request per cycle).
- Commit collision:
  - A request in the same cycle the commit edge occurs uses the old table.
  - Requests from the following cycle onward use the new table.
- Accumulator:
  - On in_valid and not in_last: acc <= acc ^ active[in_data].
  - On in_valid and in_last: acc_y <= acc ^ active[in_data], acc_valid <= 1 for one cycle, acc <= 0.
  - acc_y holds its value until the next frame end.
  - A single-beat frame (in_last on the first beat) reports that beat's LUT bit.
  - No in_valid means no change to acc.
- Reset mid-operation:
  - Reset during LOAD discards the partial load and restores the parity table.
  - Reset mid-frame clears acc; no acc_valid is issued.
- Load and evaluation run independently. There is no backpressure and no ready signal.

Test Plan:
- Reset then in_data 0..7 back-to-back (K=3) -> out_y 0,1,1,0,1,0,0,1, each one cycle after its request; out_valid continuously high.
- Serial load of 0x80 (bits 0,0,0,0,0,0,0,1) -> cfg_busy high for 8 cycles, cfg_done pulses once. Afterwards in_data 7 -> 1 and in_data 6 -> 0.
- Load of 0xFF with cfg_en dropped for 3 cycles after bit 4 -> cfg_busy stays high, no commit until the 8th qualified bit, then cfg_done; any in_data -> 1.
- in_valid with in_data 7 in the commit-edge cycle of a 0x00 load over the parity table -> out_y=1 (old table); in_data 7 on the next cycle -> 0.
- Parity table, frame in_data 1,2,3 with in_last on 3 -> acc_valid one cycle after beat 3, acc_y = 1^1^0 = 0. Next frame 4 with in_last -> acc_y=1.
- rst after 5 bits of a 0x00 load, plus a mid-frame rst -> cfg_busy=0, no cfg_done, and in_data 1 -> 1 (parity restored). A following frame 7 with in_last -> acc_y=1, with no stale accumulation.
